// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divide/remainder unit.
//   div_op_t    : operation encoding as presented on the op port
//   div_state_t : control FSM states
//   DIV_LATENCY : cycles from the accepting edge to the done pulse on a
//                 normal (non-special) operation
package div_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam int DIV_LATENCY = 33;

endpackage

// File: rtl/div_step.sv
// One iteration of restoring division, purely combinational.
//   rem      in  XLEN+1  partial remainder (always < divisor, so the top bit is 0)
//   quo      in  XLEN    quotient register; its MSB is the next dividend bit
//   divisor  in  XLEN    |b|
//   rem_next out XLEN+1  remainder after shift and trial subtract
//   quo_next out XLEN    quotient shifted left with the new quotient bit in bit 0
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    // The subtraction is done one bit wider than the remainder so the
    // borrow lands in a dedicated sign bit.
    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        diff     = shifted - {2'b00, divisor};
        rem_next = shifted[XLEN:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (!diff[XLEN+1]) begin
            rem_next    = diff[XLEN:0];
            quo_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit with a start/busy/done handshake.
//   clk     in   clock, all state on posedge
//   reset   in   synchronous active-high reset (priority over flush and start)
//   start   in   request, accepted only in IDLE without flush
//   op      in   2-bit operation select (div_op_t encoding)
//   a, b    in   dividend / divisor
//   flush   in   abort any operation in flight
//   busy    out  registered, high in RUN and DONE
//   done    out  registered single-cycle completion pulse
//   result  out  registered quotient or remainder, held between completions
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    div_state_t      state_reg, state_next;
    div_op_t         op_reg;
    logic            neg_quo_reg, neg_rem_reg;
    logic [XLEN:0]   rem_reg;
    logic [XLEN-1:0] quo_reg;
    logic [XLEN-1:0] divisor_reg;
    logic [CW-1:0]   cnt_reg;
    logic [XLEN-1:0] result_reg;
    logic            busy_reg, done_reg;

    // ---- request decode (valid in IDLE) ----
    logic            in_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] special_result;
    logic            accept, last_step;

    always_comb begin
        // op[0]=0 selects the signed variants (DIV, REM); op[1]=1 selects remainder.
        in_signed = ~op[0];
        a_neg     = in_signed & a[XLEN-1];
        b_neg     = in_signed & b[XLEN-1];
        a_abs     = a_neg ? (~a + 1'b1) : a;
        b_abs     = b_neg ? (~b + 1'b1) : b;
        div_zero  = (b == '0);
        overflow  = in_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special   = div_zero | overflow;
        // Divide by zero: quotient all ones, remainder = dividend.
        // Overflow: quotient = dividend (the most negative value), remainder 0.
        if (div_zero) begin
            special_result = op[1] ? a : '1;
        end else begin
            special_result = op[1] ? '0 : a;
        end
        accept    = (state_reg == IDLE) && start && !flush;
        last_step = (state_reg == RUN) && (cnt_reg == '0);
    end

    // ---- datapath iteration ----
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (divisor_reg),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Sign fix applied to the outputs of the final step so the result can
    // be registered on the same edge that moves the FSM to DONE.
    logic [XLEN-1:0] quo_fixed, rem_fixed, final_result;

    always_comb begin
        quo_fixed    = neg_quo_reg ? (~step_quo + 1'b1) : step_quo;
        rem_fixed    = neg_rem_reg ? (~step_rem[XLEN-1:0] + 1'b1) : step_rem[XLEN-1:0];
        final_result = ((op_reg == DIV_OP_REM) || (op_reg == DIV_OP_REMU)) ? rem_fixed : quo_fixed;
    end

    // ---- control FSM ----
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = special ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Derived from the next state so both outputs come straight from flops.
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg      <= DIV_OP_DIV;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
        end else if (accept) begin
            op_reg      <= div_op_t'(op);
            neg_quo_reg <= a_neg ^ b_neg;
            neg_rem_reg <= a_neg;
            rem_reg     <= '0;
            quo_reg     <= a_abs;
            divisor_reg <= b_abs;
            cnt_reg     <= CW'(XLEN - 1);
            if (special) begin
                result_reg <= special_result;
            end
        end else if ((state_reg == RUN) && !flush) begin
            rem_reg <= step_rem;
            quo_reg <= step_quo;
            if (last_step) begin
                result_reg <= final_result;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a vector table of operations with
// hand-computed results and latencies, plus sequences for flush,
// ignored start, mid-operation reset and flush+start in IDLE.
module tb_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    always #5 clk = ~clk;

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    // Called just after a negedge. Drives start for one edge, then watches
    // lat+1 cycles: busy must be high for cycles 1..lat and low at lat+1,
    // done must pulse exactly once, at cycle lat, with the expected result.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] e, input int lat);
        int          first    = -1;
        int          dcount   = 0;
        int          busy_bad = 0;
        logic [31:0] res_at   = '0;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (busy !== (k <= lat)) busy_bad++;
            if (done === 1'b1) begin
                dcount++;
                if (first < 0) begin
                    first  = k;
                    res_at = result;
                end
            end
        end
        $display("tx %-14s op=%0d a=0x%08h b=0x%08h -> result=0x%08h (exp 0x%08h) done@T+%0d",
                 name, o, x, y, res_at, e, first);
        check({name, " latency"},    32'(first),    32'(lat));
        check({name, " done count"}, 32'(dcount),   32'd1);
        check({name, " result"},     res_at,        e);
        check({name, " busy"},       32'(busy_bad), 32'd0);
    endtask

    initial begin
        int          dcount;
        int          first;
        int          busy_bad;
        logic [31:0] res_at;
        logic [31:0] prev;

        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         DIV_LATENCY};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          DIV_LATENCY};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  DIV_LATENCY};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  DIV_LATENCY};
        vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          DIV_LATENCY};
        vecs[5]  = '{2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[6]  = '{2'b10, 32'h1234_5678,  32'd0,          32'h1234_5678,  1};
        vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[9]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  DIV_LATENCY};
        vecs[10] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  DIV_LATENCY};
        vecs[11] = '{2'b01, 32'd5,          32'd10,         32'd0,          DIV_LATENCY};
        vecs[12] = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          DIV_LATENCY};
        vecs[13] = '{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  DIV_LATENCY};
        vecs[14] = '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  DIV_LATENCY};
        vecs[15] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          DIV_LATENCY};
        vecs[16] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  DIV_LATENCY};
        vecs[17] = '{2'b01, 32'd1000,       32'd3,          32'd333,        DIV_LATENCY};

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset busy",   32'(busy),   32'd0);
        check("reset done",   32'(done),   32'd0);
        check("reset result", result,      32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back table: each start lands at T+34 of the previous one.
        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end
        prev = vecs[17].exp;

        // Flush at T+10: idle at T+11, no done, result untouched.
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
            if (k == 10) flush = 1'b1;
        end
        flush = 1'b0;
        $display("tx flush         busy@T+11=%0b result=0x%08h done pulses=%0d", busy, result, dcount);
        check("flush busy",   32'(busy),   32'd0);
        check("flush result", result,      prev);
        check("flush done",   32'(dcount), 32'd0);
        run_op("flush_restart", 2'b01, 32'd9, 32'd3, 32'd3, DIV_LATENCY);

        // Start pulse with other operands at T+5 must be ignored.
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0; first = -1; res_at = '0; busy_bad = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (busy !== (k <= 33)) busy_bad++;
            if (done === 1'b1) begin
                dcount++;
                if (first < 0) begin
                    first  = k;
                    res_at = result;
                end
            end
            if (k == 5) begin
                op = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
            end
            if (k == 6) start = 1'b0;
        end
        $display("tx ignore_start  result=0x%08h done@T+%0d pulses=%0d", res_at, first, dcount);
        check("ignore latency", 32'(first),    32'd33);
        check("ignore result",  res_at,        32'd14);
        check("ignore count",   32'(dcount),   32'd1);
        check("ignore busy",    32'(busy_bad), 32'd0);

        // Reset at T+20: everything cleared next cycle, no done afterwards.
        op = 2'b01; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 21) begin
                $display("tx reset_mid     busy=%0b done=%0b result=0x%08h", busy, done, result);
                check("midreset busy",   32'(busy), 32'd0);
                check("midreset done",   32'(done), 32'd0);
                check("midreset result", result,    32'd0);
                reset = 1'b0;
            end else if (done === 1'b1) begin
                dcount++;
            end
            if (k == 20) reset = 1'b1;
        end
        check("midreset no done", 32'(dcount), 32'd0);
        run_op("post_reset", 2'b01, 32'd100, 32'd7, 32'd14, DIV_LATENCY);

        // start together with flush in IDLE: nothing accepted.
        op = 2'b01; a = 32'd9; b = 32'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        busy_bad = 0; dcount = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_bad++;
            if (done === 1'b1) dcount++;
        end
        $display("tx start+flush   busy cycles=%0d done pulses=%0d result=0x%08h", busy_bad, dcount, result);
        check("startflush busy",   32'(busy_bad), 32'd0);
        check("startflush done",   32'(dcount),   32'd0);
        check("startflush result", result,        32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide/remainder unit in the execute stage, directly downstream of the register file. It takes the two source operands read from the register file (rs1, rs2) and computes DIV, DIVU, REM or REMU by 32-step restoring division. It runs a start/busy/done handshake with the core's hazard logic, which stalls the pipeline while `busy` is high. The registered result is then routed back to the register-file write-data path.

## Interface
- XLEN, 32, operand/result width; only 32 is supported and verified.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only while `busy`=0.
- op  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  in  XLEN  dividend (rs1 from register file).
- b  in  XLEN  divisor (rs2 from register file).
- flush  in  1  synchronous abort of any operation in flight.
- busy  out  1  high in RUN and DONE.
- done  out  1  single-cycle pulse; `result` is valid in this cycle.
- result  out  XLEN  registered quotient or remainder.

## Operation
- State machine: IDLE, RUN, DONE.
  - IDLE, start=1: latch op, signs and absolute values of a and b.
    - If b=0 or signed overflow: write the special result and go to DONE.
    - Otherwise: clear remainder, load the quotient register with |a|, set the step counter to 31, go to RUN.
  - RUN, each cycle:
    - Shift {rem,quo} left by 1.
    - Trial-subtract |b| from the 33-bit remainder.
    - If the result is non-negative, keep it and set quo[0]=1.
    - Counter decrements. At counter=0, apply sign fix, register `result`, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Signed (DIV/REM) operations take absolute values first:
  - Quotient is negated if a[31]^b[31].
  - Remainder is negated if a[31] (remainder takes the sign of the dividend).
  - Quotient truncates toward zero.
- Unsigned operations skip the sign handling.
- Special cases (RISC-V defined, no trap):
  - b=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - DIV with a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM in the same case → 0.
- `result` holds its last value until the next completion; it changes only on the cycle before `done`.
- `start` while `busy`=1 is ignored; operands are not re-sampled.
- `start` and `flush` together in IDLE: flush wins and nothing is accepted.
- `flush` in RUN or DONE: go to IDLE next cycle. `done` is not asserted and `result` keeps its previous value.
- `reset`, including mid-operation: state IDLE, busy=0, done=0, result=0, counter=0. Reset has priority over flush and start.

## Timing
- The accepting edge is at the end of cycle T.
- Normal operation:
  - RUN occupies cycles T+1..T+32.
  - `done`=1 and `result` valid in T+33.
  - `busy` is high T+1..T+33 and low in T+34.
  - A new start can be accepted in T+34, so throughput is one operation per 34 cycles.
- Special case (b=0 or overflow): DONE in T+1, `done` at T+1, `busy` high T+1 only.
- `busy` and `done` are registered outputs with no combinational path from inputs.
- The `done` pulse lasts exactly one cycle.

## Structure
- Shared package `div_pkg` holds:
  - `div_op_t` enum: DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU.
  - `div_state_t` enum: IDLE, RUN, DONE.
  - Constant DIV_LATENCY=33.
- Sub-module `div_step`: purely combinational, one shift/trial-subtract iteration.
  - Inputs: rem (33 bits), quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once and used iteratively.
- Sign-fix and special-case logic lives in the top module.

## Test plan
- DIVU a=100, b=7, start at T: `busy` high T+1..T+33; `done` only at T+33 with result=14. REMU with the same operands gives result=2.
- DIV a=0xFFFFFFF9 (-7), b=2 gives 0xFFFFFFFD (-3). REM gives 0xFFFFFFFF (-1). REM with a=7, b=0xFFFFFFFE gives 1.
- Divide by zero, a=0x12345678, b=0: DIVU → 0xFFFFFFFF and REM → 0x12345678, both with `done` at T+1.
- Overflow, DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 at T+1. REM with the same operands → 0.
- Flush at T+10 during a run:
  - No `done` pulse; `busy`=0 at T+11; `result` unchanged.
  - A new DIVU 9/3 started at T+11 returns 3 at T+44.
- Pulse `start` with different operands at T+5 during a run:
  - Ignored; the original result appears at T+33.
- Assert `reset` at T+20:
  - busy=0, done=0, result=0 next cycle.
  - No `done` pulse follows.
